// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blitter
// Brief    : Draws one 8-direction sprite from straight/diagonal ROM images
//            into the VGA pixel port with transparency, clipping and erase.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
    parameter int    X_SCREEN_PIXELS = 160,
    parameter int    Y_SCREEN_PIXELS = 120,
    parameter int    ST_W            = 8,
    parameter int    ST_H            = 14,
    parameter int    DG_N            = 15,
    parameter int    COLOUR_W        = 10,
    parameter string ST_INIT         = "car_straight.mem",
    parameter string DG_INIT         = "car_diag.mem"
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [7:0]          iX,
    input  logic [6:0]          iY,
    input  logic [2:0]          iDir,
    input  logic                iErase,
    input  logic [COLOUR_W-1:0] iBgColour,
    output logic [7:0]          oX,
    output logic [6:0]          oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);
    localparam int ST_DEPTH = ST_W * ST_H;
    localparam int DG_DEPTH = DG_N * DG_N;
    localparam int ST_AW    = $clog2(ST_DEPTH);
    localparam int DG_AW    = $clog2(DG_DEPTH);
    localparam int DIM_MAX  = (ST_H > ST_W) ? ((DG_N > ST_H) ? DG_N : ST_H)
                                            : ((DG_N > ST_W) ? DG_N : ST_W);
    localparam int CNT_W    = $clog2(DIM_MAX + 1);
    localparam logic [8:0] XLIM = 9'(X_SCREEN_PIXELS);
    localparam logic [7:0] YLIM = 8'(Y_SCREEN_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    logic [COLOUR_W-1:0] st_rom [0:ST_DEPTH-1];
    logic [COLOUR_W-1:0] dg_rom [0:DG_DEPTH-1];

    state_t              state_q, state_d;
    logic [7:0]          x0_q, x0_d;
    logic [6:0]          y0_q, y0_d;
    logic [2:0]          dir_q, dir_d;
    logic                erase_q, erase_d;
    logic [COLOUR_W-1:0] bg_q, bg_d;
    logic [CNT_W-1:0]    col_q, col_d, row_q, row_d;
    logic                flush_q, flush_d;

    logic [CNT_W-1:0]    w_last_col, w_last_row;
    logic [ST_AW-1:0]    w_st_addr;
    logic [DG_AW-1:0]    w_dg_addr;
    int                  w_c, w_r, w_sa, w_da;

    logic [COLOUR_W-1:0] st_data_q, dg_data_q;
    logic                p1_valid_q;
    logic [8:0]          p1_x_q;
    logic [7:0]          p1_y_q;
    logic [COLOUR_W-1:0] w_pix;
    logic                w_plot;

    logic [7:0]          x_q;
    logic [6:0]          y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q, busy_q, done_q;

    always_comb begin
        case (dir_q)
            3'd0, 3'd4: begin
                w_last_col = CNT_W'(ST_W - 1);
                w_last_row = CNT_W'(ST_H - 1);
            end
            3'd2, 3'd6: begin
                w_last_col = CNT_W'(ST_H - 1);
                w_last_row = CNT_W'(ST_W - 1);
            end
            default: begin
                w_last_col = CNT_W'(DG_N - 1);
                w_last_row = CNT_W'(DG_N - 1);
            end
        endcase
    end

    // E/W are the straight image rotated by 90 degrees; the other diagonals
    // are mirrors of the NE image.
    always_comb begin
        w_c = int'(col_q);
        w_r = int'(row_q);
        case (dir_q)
            3'd0:    w_sa = w_r * ST_W + w_c;
            3'd4:    w_sa = (ST_H - 1 - w_r) * ST_W + (ST_W - 1 - w_c);
            3'd2:    w_sa = (ST_H - 1 - w_c) * ST_W + w_r;
            3'd6:    w_sa = w_c * ST_W + (ST_W - 1 - w_r);
            default: w_sa = 0;
        endcase
        case (dir_q)
            3'd1:    w_da = w_r * DG_N + w_c;
            3'd3:    w_da = (DG_N - 1 - w_r) * DG_N + w_c;
            3'd7:    w_da = w_r * DG_N + (DG_N - 1 - w_c);
            3'd5:    w_da = (DG_N - 1 - w_r) * DG_N + (DG_N - 1 - w_c);
            default: w_da = 0;
        endcase
        w_st_addr = ST_AW'(w_sa);
        w_dg_addr = DG_AW'(w_da);
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        dir_d   = dir_q;
        erase_d = erase_q;
        bg_d    = bg_q;
        col_d   = col_q;
        row_d   = row_q;
        flush_d = flush_q;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    x0_d    = iX;
                    y0_d    = iY;
                    dir_d   = iDir;
                    erase_d = iErase;
                    bg_d    = iBgColour;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (col_q == w_last_col) begin
                    col_d = '0;
                    if (row_q == w_last_row) begin
                        flush_d = 1'b0;
                        state_d = S_FLUSH;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            dir_q   <= '0;
            erase_q <= 1'b0;
            bg_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            dir_q   <= dir_d;
            erase_q <= erase_d;
            bg_q    <= bg_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flush_q <= flush_d;
        end
    end

    always_ff @(posedge iClock) begin
        st_data_q <= st_rom[w_st_addr];
        dg_data_q <= dg_rom[w_dg_addr];
    end

    // Coordinates travel alongside the ROM read so they line up with its data.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            p1_valid_q <= 1'b0;
            p1_x_q     <= '0;
            p1_y_q     <= '0;
        end else begin
            p1_valid_q <= (state_q == S_SCAN);
            p1_x_q     <= {1'b0, x0_q} + 9'(col_q);
            p1_y_q     <= {1'b0, y0_q} + 8'(row_q);
        end
    end

    assign w_pix  = dir_q[0] ? dg_data_q : st_data_q;
    assign w_plot = p1_valid_q && (w_pix != '0) && (p1_x_q < XLIM) && (p1_y_q < YLIM);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_d == S_SCAN) || (state_d == S_FLUSH);
            done_q <= (state_d == S_DONE);
            plot_q <= w_plot;
            if (p1_valid_q) begin
                x_q <= p1_x_q[7:0];
                y_q <= p1_y_q[6:0];
            end
            if (w_plot) begin
                colour_q <= erase_q ? bg_q : w_pix;
            end
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blitter
// Brief    : Self-checking bench for sprite_blitter against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;
    localparam int XS = 160;
    localparam int YS = 120;
    localparam int SW = 8;
    localparam int SH = 14;
    localparam int DN = 15;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    ix = '0;
    logic [6:0]    iy = '0;
    logic [2:0]    dir = '0;
    logic          erase = 1'b0;
    logic [CW-1:0] bg = '0;
    logic [7:0]    ox;
    logic [6:0]    oy;
    logic [CW-1:0] ocol;
    logic          oplot, obusy, odone;

    int vectors = 0;
    int miscompares = 0;

    logic [CW-1:0] srom [SW*SH];
    logic [CW-1:0] drom [DN*DN];
    logic [CW-1:0] last_col = '0;

    always #5 clk = ~clk;

    sprite_blitter #(
        .X_SCREEN_PIXELS(XS), .Y_SCREEN_PIXELS(YS), .ST_W(SW), .ST_H(SH),
        .DG_N(DN), .COLOUR_W(CW), .ST_INIT(""), .DG_INIT("")
    ) dut (
        .iClock(clk), .iReset(rst), .iStart(start), .iX(ix), .iY(iy),
        .iDir(dir), .iErase(erase), .iBgColour(bg), .oX(ox), .oY(oy),
        .oColour(ocol), .oPlot(oplot), .oBusy(obusy), .oDone(odone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] st_px(input int row, input int col);
        return srom[row * SW + col];
    endfunction

    function automatic logic [CW-1:0] dg_px(input int row, input int col);
        return drom[row * DN + col];
    endfunction

    // Source pixel for oriented-box position (c,r).
    function automatic logic [CW-1:0] pix(input int d, input int c, input int r);
        case (d)
            0:       return st_px(r, c);
            4:       return st_px(SH - 1 - r, SW - 1 - c);
            2:       return st_px(SH - 1 - c, r);
            6:       return st_px(c, SW - 1 - r);
            1:       return dg_px(r, c);
            3:       return dg_px(DN - 1 - r, c);
            7:       return dg_px(r, DN - 1 - c);
            default: return dg_px(DN - 1 - r, DN - 1 - c);
        endcase
    endfunction

    task automatic check_all_zero();
        chk("rst_x", ox, 0);
        chk("rst_y", oy, 0);
        chk("rst_colour", ocol, 0);
        chk("rst_plot", oplot, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_done", odone, 0);
    endtask

    task automatic draw(input int x0, input int y0, input int d, input bit er,
                        input logic [CW-1:0] bgc, input bit noise, input int abort_at,
                        output int nplot);
        int bw, bh, n, k, c, r, xe, ye;
        logic [CW-1:0] v;
        bit pe;
        if (d == 0 || d == 4) begin bw = SW; bh = SH; end
        else if (d == 2 || d == 6) begin bw = SH; bh = SW; end
        else begin bw = DN; bh = DN; end
        n = bw * bh;
        nplot = 0;
        ix = x0[7:0]; iy = y0[6:0]; dir = d[2:0]; erase = er; bg = bgc; start = 1'b1;
        for (int t = 1; t <= n + 3; t++) begin
            @(posedge clk); #1;
            if (t == 1) start = 1'b0;
            k = t - 3;
            if (k >= 0 && k < n) begin
                c = k % bw; r = k / bw;
                v = pix(d, c, r);
                xe = x0 + c; ye = y0 + r;
                pe = (v != '0) && (xe < XS) && (ye < YS);
                if (pe) begin
                    last_col = er ? bgc : v;
                    nplot++;
                end
                chk("plot", oplot, pe);
                chk("x", ox, xe[7:0]);
                chk("y", oy, ye[6:0]);
            end else begin
                chk("plot_idle", oplot, 0);
            end
            chk("colour", ocol, last_col);
            chk("busy", obusy, t <= n + 2);
            chk("done", odone, t == n + 3);
            if (t == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_all_zero();
                last_col = '0;
                return;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                ix = 8'($urandom); iy = 7'($urandom); dir = 3'($urandom);
                erase = 1'($urandom); bg = CW'($urandom);
                if (t == n + 3) start = 1'b1;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk("post_busy", obusy, 0);
        chk("post_done", odone, 0);
        chk("post_plot", oplot, 0);
    endtask

    initial begin
        int np, np2, nz;
        for (int i = 0; i < SW * SH; i++)
            srom[i] = ($urandom_range(0, 9) < 3) ? '0 : CW'($urandom_range(1, 1023));
        for (int i = 0; i < DN * DN; i++)
            drom[i] = ($urandom_range(0, 9) < 3) ? '0 : CW'($urandom_range(1, 1023));
        srom[0] = 10'h200; srom[2] = '0; srom[3] = '0; srom[13 * SW] = 10'h200;
        for (int i = 0; i < SW * SH; i++) dut.st_rom[i] = srom[i];
        for (int i = 0; i < DN * DN; i++) dut.dg_rom[i] = drom[i];

        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;
        @(posedge clk); #1;

        draw(10, 20, 0, 1'b0, '0, 1'b0, -1, np);
        draw(0, 0, 2, 1'b0, '0, 1'b0, -1, np);

        draw(40, 40, 5, 1'b0, '0, 1'b0, -1, np);
        nz = 0;
        for (int i = 0; i < DN * DN; i++) if (drom[i] != '0) nz++;
        chk("sw_plot_count", np, nz);

        draw(155, 10, 0, 1'b0, '0, 1'b0, -1, np);

        draw(30, 30, 4, 1'b0, '0, 1'b0, -1, np);
        draw(30, 30, 4, 1'b1, 10'h0AA, 1'b0, -1, np2);
        chk("erase_plot_count", np2, np);

        draw(10, 20, 0, 1'b0, '0, 1'b0, 50, np);
        @(posedge clk); #1;
        draw(10, 20, 0, 1'b0, '0, 1'b0, -1, np);

        draw(60, 50, 3, 1'b0, '0, 1'b1, -1, np);
        draw(150, 110, 7, 1'b1, 10'h155, 1'b1, -1, np);

        for (int i = 0; i < 20; i++)
            draw(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 7)), 1'($urandom), CW'($urandom),
                 1'($urandom), -1, np);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
